// File: rtl/clken_pkg.sv
// Shared types and constants for the fractional clock-enable generator.
package clken_pkg;

    localparam int unsigned ACC_W_DEFAULT = 16;
    localparam int unsigned MAX_CH        = 8;
    localparam int unsigned CH_SEL_W      = $clog2(MAX_CH);

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } lock_state_t;

    typedef struct packed {
        logic [ACC_W_DEFAULT-1:0] num;
        logic [ACC_W_DEFAULT-1:0] den;
    } ch_cfg_t;

endpackage

// File: rtl/clken_frac_ch.sv
// One fractional enable channel: phase accumulator producing ce at NUM/DEN of
// the clock rate. With CLKEN_RUNTIME_CFG_EN defined, a shadow NUM/DEN is
// loaded by cfg_we and applied right after the next ce (or at once if the
// channel is off) so a rate change never produces a runt interval.
module clken_frac_ch
    import clken_pkg::*;
#(
    parameter int unsigned      ACC_W    = ACC_W_DEFAULT,
    parameter logic [ACC_W-1:0] NUM_INIT = ACC_W'(1),
    parameter logic [ACC_W-1:0] DEN_INIT = ACC_W'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
`ifdef CLKEN_RUNTIME_CFG_EN
    input  logic             cfg_we,
    input  logic [ACC_W-1:0] cfg_num,
    input  logic [ACC_W-1:0] cfg_den,
`endif
    output logic             ce
);

    logic [ACC_W-1:0] num;
    logic [ACC_W-1:0] den;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic             off;

    assign sum = {1'b0, acc} + {1'b0, num};
    assign off = (num == '0) || (den == '0);

`ifdef CLKEN_RUNTIME_CFG_EN
    logic [ACC_W-1:0] shadow_num;
    logic [ACC_W-1:0] shadow_den;
    logic             pending;

    // Shadow capture and deferred apply of the channel rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            num        <= NUM_INIT;
            den        <= DEN_INIT;
            shadow_num <= NUM_INIT;
            shadow_den <= DEN_INIT;
            pending    <= 1'b0;
        end else begin
            if (pending && (ce || off)) begin
                num     <= shadow_num;
                den     <= shadow_den;
                pending <= 1'b0;
            end
            if (cfg_we) begin
                shadow_num <= cfg_num;
                shadow_den <= cfg_den;
                pending    <= 1'b1;
            end
        end
    end
`else
    assign num = NUM_INIT;
    assign den = DEN_INIT;
`endif

    // Phase accumulator; cleared whenever the generator is not running.
    always_ff @(posedge clk) begin
        if (rst || !run || off) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (num >= den) begin
            acc <= '0;
            ce  <= 1'b1;
        end else if (sum >= {1'b0, den}) begin
            acc <= ACC_W'(sum - {1'b0, den});
            ce  <= 1'b1;
        end else begin
            acc <= ACC_W'(sum);
            ce  <= 1'b0;
        end
    end

endmodule

// File: rtl/clken_frac_gen.sv
// Fractional clock-enable generator behind the PLL: lock synchroniser,
// lock-hold FSM producing ready, and NUM_CH phase-coherent enable channels.
// Optional runtime rate writes via cfg_* when CLKEN_RUNTIME_CFG_EN is defined.
module clken_frac_gen
    import clken_pkg::*;
#(
    parameter int unsigned                   NUM_CH    = 2,
    parameter int unsigned                   ACC_W     = ACC_W_DEFAULT,
    parameter int unsigned                   LOCK_HOLD = 1024,
    parameter logic [NUM_CH*ACC_W-1:0]       NUM_INIT  = {16'd1, 16'd1},
    parameter logic [NUM_CH*ACC_W-1:0]       DEN_INIT  = {16'd5, 16'd1}
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    output logic                ready,
    output logic [NUM_CH-1:0]   ce
`ifdef CLKEN_RUNTIME_CFG_EN
    ,
    input  logic                cfg_we,
    input  logic [CH_SEL_W-1:0] cfg_ch,
    input  logic [ACC_W-1:0]    cfg_num,
    input  logic [ACC_W-1:0]    cfg_den
`endif
);

    localparam int unsigned HOLD_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;

    logic [1:0]        lk_sync;
    logic              lk_s;
    lock_state_t       state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              run_en;

    assign lk_s = lk_sync[1];
    // Channels advance only while ready stays high, so ce drops with ready.
    assign run_en = ready && lk_s;

    // Two-flop synchroniser for the asynchronous PLL lock flag.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lk_sync <= 2'b00;
        end else begin
            lk_sync <= {lk_sync[0], pll_locked};
        end
    end

    // Lock FSM: require LOCK_HOLD stable cycles of lk_s before ready.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state    <= ST_RESET;
            hold_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                ST_RESET: begin
                    state <= ST_WAIT_LOCK;
                    ready <= 1'b0;
                end
                ST_WAIT_LOCK: begin
                    ready <= 1'b0;
                    if (lk_s) begin
                        state    <= ST_HOLD;
                        hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (!lk_s) begin
                        state <= ST_WAIT_LOCK;
                    end else if (hold_cnt == HOLD_W'(LOCK_HOLD - 1)) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lk_s) begin
                        state <= ST_WAIT_LOCK;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RESET;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // One accumulator channel per enable output.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef CLKEN_RUNTIME_CFG_EN
        logic ch_we;
        assign ch_we = cfg_we && (cfg_ch == CH_SEL_W'(i));
`endif
        clken_frac_ch #(
            .ACC_W    (ACC_W),
            .NUM_INIT (NUM_INIT[i*ACC_W +: ACC_W]),
            .DEN_INIT (DEN_INIT[i*ACC_W +: ACC_W])
        ) u_ch (
            .clk     (refclk),
            .rst     (rst),
            .run     (run_en),
`ifdef CLKEN_RUNTIME_CFG_EN
            .cfg_we  (ch_we),
            .cfg_num (cfg_num),
            .cfg_den (cfg_den),
`endif
            .ce      (ce[i])
        );
    end

endmodule

// File: tb/tb_clken_frac_gen.sv
// Bench for clken_frac_gen: five channels (1/5, 1/1, 3/8, 0/7, 3/0), LOCK_HOLD=4.
// Covers CLKEN_RUNTIME_CFG_EN when that macro is defined.
module tb_clken_frac_gen;

    localparam int unsigned NCH = 5;

    logic           refclk = 1'b0;
    logic           rst;
    logic           pll_locked;
    logic           ready;
    logic [NCH-1:0] ce;
`ifdef CLKEN_RUNTIME_CFG_EN
    logic           cfg_we;
    logic [2:0]     cfg_ch;
    logic [15:0]    cfg_num;
    logic [15:0]    cfg_den;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int off_hits = 0;

    typedef struct {
        logic           rdy;
        logic [NCH-1:0] ce;
    } vec_t;

    vec_t tbl[23];

    clken_frac_gen #(
        .NUM_CH    (NCH),
        .ACC_W     (16),
        .LOCK_HOLD (4),
        .NUM_INIT  ({16'd3, 16'd0, 16'd3, 16'd1, 16'd1}),
        .DEN_INIT  ({16'd0, 16'd7, 16'd8, 16'd1, 16'd5})
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .ready      (ready),
        .ce         (ce)
`ifdef CLKEN_RUNTIME_CFG_EN
        ,
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_num    (cfg_num),
        .cfg_den    (cfg_den)
`endif
    );

    always #5 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    // Channels with NUM=0 or DEN=0 must never strobe.
    always @(negedge refclk) if (ce[4:3] != 2'b00) off_hits <= off_hits + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, last2, gap_bad, found;

        // Cycle i counted from the first cycle after the last reset edge.
        // R=7; ch0 at 12,17,22; ch1 from 8; ch2 at 10,13,15,18,21.
        for (int i = 0; i < 7; i++) tbl[i] = '{1'b0, 5'b00000};
        tbl[7]  = '{1'b1, 5'b00000};
        tbl[8]  = '{1'b1, 5'b00010};
        tbl[9]  = '{1'b1, 5'b00010};
        tbl[10] = '{1'b1, 5'b00110};
        tbl[11] = '{1'b1, 5'b00010};
        tbl[12] = '{1'b1, 5'b00011};
        tbl[13] = '{1'b1, 5'b00110};
        tbl[14] = '{1'b1, 5'b00010};
        tbl[15] = '{1'b1, 5'b00110};
        tbl[16] = '{1'b1, 5'b00010};
        tbl[17] = '{1'b1, 5'b00011};
        tbl[18] = '{1'b1, 5'b00110};
        tbl[19] = '{1'b1, 5'b00010};
        tbl[20] = '{1'b1, 5'b00010};
        tbl[21] = '{1'b1, 5'b00110};
        tbl[22] = '{1'b1, 5'b00011};

        rst = 1'b1;
        pll_locked = 1'b1;
`ifdef CLKEN_RUNTIME_CFG_EN
        cfg_we = 1'b0;
        cfg_ch = 3'd0;
        cfg_num = 16'd0;
        cfg_den = 16'd0;
`endif
        repeat (3) @(negedge refclk);

        // Startup table: entry 0 is the reset state itself.
        for (int i = 0; i < 23; i++) begin
            if (i > 0) @(negedge refclk);
            check($sformatf("tbl%0d_ready", i), int'(ready), int'(tbl[i].rdy));
            check($sformatf("tbl%0d_ce", i), int'(ce), int'(tbl[i].ce));
            if (i == 0) rst = 1'b0;
        end

        // Long run: 800 cycles, ch2 (3/8) must give 300 pulses spaced 2 or 3.
        c0 = 0; c1 = 0; c2 = 0; last2 = -1; gap_bad = 0;
        for (int k = 0; k < 800; k++) begin
            @(negedge refclk);
            if (ce[0]) c0++;
            if (ce[1]) c1++;
            if (ce[2]) begin
                c2++;
                if (last2 >= 0 && (k - last2 < 2 || k - last2 > 3)) gap_bad++;
                last2 = k;
            end
        end
        check("run_ch0_count", c0, 160);
        check("run_ch1_count", c1, 800);
        check("run_ch2_count", c2, 300);
        check("run_ch2_gap", gap_bad, 0);

        // Drop pll_locked for one cycle (cycle t), then relock.
        @(negedge refclk);
        pll_locked = 1'b0;
        @(negedge refclk);
        pll_locked = 1'b1;
        for (int rel = 2; rel <= 14; rel++) begin
            @(negedge refclk);
            check($sformatf("drop%0d_ready", rel), int'(ready),
                  (rel <= 2 || rel >= 8) ? 1 : 0);
            if (rel >= 3) begin
                check($sformatf("drop%0d_ce0", rel), int'(ce[0]), (rel == 13) ? 1 : 0);
                check($sformatf("drop%0d_ce1", rel), int'(ce[1]), (rel >= 9) ? 1 : 0);
            end
        end

        // Reset in the middle of RUN, then a fresh start.
        @(negedge refclk);
        rst = 1'b1;
        @(negedge refclk);
        check("midrst_ready", int'(ready), 0);
        check("midrst_ce", int'(ce), 0);
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge refclk);
            check($sformatf("rst%0d_ready", i), int'(ready), (i >= 7) ? 1 : 0);
            check($sformatf("rst%0d_ce0", i), int'(ce[0]), (i == 12) ? 1 : 0);
            check($sformatf("rst%0d_ce1", i), int'(ce[1]), (i >= 8) ? 1 : 0);
        end

`ifdef CLKEN_RUNTIME_CFG_EN
        // Runtime write: ignored channel 7, then ch0 -> 1/3 between pulses.
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge refclk);
            if (ce[0]) found = 1;
        end
        check("cfg_wait_pulse", found, 1);
        @(negedge refclk);
        cfg_we = 1'b1; cfg_ch = 3'd7; cfg_num = 16'd1; cfg_den = 16'd2;
        @(negedge refclk);
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_num = 16'd1; cfg_den = 16'd3;
        for (int rel = 3; rel <= 12; rel++) begin
            @(negedge refclk);
            cfg_we = 1'b0;
            check($sformatf("cfg%0d_ce0", rel), int'(ce[0]),
                  (rel == 5 || rel == 8 || rel == 11) ? 1 : 0);
            check($sformatf("cfg%0d_ce1", rel), int'(ce[1]), 1);
        end
`else
        found = 1;
        check("static_cfg_ch1", int'(ce[1]), found);
`endif

        check("off_channels_quiet", off_hits, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clken_frac_gen.md
# clken_frac_gen

Parametrised clock-enable generator clocked by the system PLL output. Produces NUM_CH phase-coherent fractional clock-enable strobes (f_ce = f_clk × NUM/DEN) plus a debounced ready flag derived from the PLL locked output. It sits directly behind the PLL, so only one fast clock is needed; subsystem rates such as 17.734375 MHz from 88.671875 MHz (NUM=1, DEN=5) become single-cycle enables instead of extra PLL outputs.

## Interface
- NUM_CH, 2, number of enable channels (1..8)
- ACC_W, 16, width of NUM/DEN and accumulators
- LOCK_HOLD, 1024, cycles of stable sync'd lock required before ready (≥1)
- NUM_INIT, {16'd1,16'd1}, packed NUM_CH×ACC_W initial numerators, channel 0 in LSBs
- DEN_INIT, {16'd5,16'd1}, packed NUM_CH×ACC_W initial denominators
- refclk  in  1  fast system clock (PLL outclk_0)
- rst  in  1  synchronous reset, active-high
- pll_locked  in  1  asynchronous PLL locked flag
- ready  out  1  lock stable, enables running
- ce  out  NUM_CH  one-cycle enable strobe per channel
- cfg_we  in  1  runtime write strobe (CLKEN_RUNTIME_CFG_EN only)
- cfg_ch  in  3  target channel
- cfg_num  in  ACC_W  new numerator
- cfg_den  in  ACC_W  new denominator

## Operation
- pll_locked passes a 2-flop synchroniser → lk_s.
- Lock FSM, states: RESET, WAIT_LOCK, HOLD, RUN.
  - rst → RESET; next cycle WAIT_LOCK.
  - WAIT_LOCK: lk_s=1 → HOLD, hold counter cleared.
  - HOLD: counter increments; lk_s=0 → WAIT_LOCK; counter reaches LOCK_HOLD−1 → RUN.
  - RUN: ready=1; lk_s=0 → WAIT_LOCK immediately (ready drops next cycle).
- Channel i, while ready=0: acc=0, ce[i]=0.
- Channel i, each RUN cycle: sum = acc + NUM (ACC_W+1 bits); if sum ≥ DEN then acc ← sum − DEN, ce[i] ← 1; else acc ← sum, ce[i] ← 0.
- All accumulators leave 0 on the same cycle, so channels are phase-coherent after every lock.
- Boundaries:
  - DEN=0 or NUM=0: channel off, ce=0.
  - NUM ≥ DEN: ce=1 every RUN cycle; acc held at 0.
  - Long-run average is exact: pulse count over k cycles is floor(k·NUM/DEN).

## Timing
- Reset values: ready=0, ce=0, all acc=0, FSM RESET, hold counter 0.
- pll_locked rise → lk_s: 2 cycles; lk_s → ready: LOCK_HOLD+1 cycles.
- ready first high in cycle R → first ce for NUM=1 in cycle R+DEN, then every DEN cycles.
- ce registered, high exactly one cycle per event (except NUM ≥ DEN).
- Lock loss: ce forced 0 in the same cycle ready falls.
- rst mid-run: next cycle all outputs at reset values.

## Configuration
- CLKEN_RUNTIME_CFG_EN defined: cfg_* ports present.
  - cfg_we with cfg_ch < NUM_CH loads a per-channel shadow NUM/DEN and sets pending; the write is applied the cycle after that channel's next ce (glitch-free rate change).
  - A channel with ce=0 constantly applies pending immediately.
  - A second write before apply overwrites the shadow.
  - cfg_ch ≥ NUM_CH is ignored.
  - Shadow and pending survive lock loss; rst restores NUM_INIT/DEN_INIT.
- CLKEN_RUNTIME_CFG_EN undefined: cfg_* ports absent; NUM/DEN fixed at INIT parameters.

## Structure
- Package clken_pkg: ACC_W default, lock FSM state enum, per-channel config struct {num, den}, MAX_CH=8.
- Sub-module clken_frac_ch: one accumulator plus shadow/pending logic, instantiated NUM_CH times by generate.
- Top level holds the synchroniser, lock FSM and hold counter.

## Test plan
- Reset with lock high from start, LOCK_HOLD=4 → ready high 7 cycles after rst release (sync 2 + FSM step + hold); ce=0 until then.
- Ch0 NUM=1 DEN=5, ch1 NUM=1 DEN=1 → ch0 pulses R+5, R+10 …; ch1 high every cycle.
- NUM=3 DEN=8 over 800 cycles → exactly 300 pulses, spacing 2 or 3 cycles only.
- Drop pll_locked for 1 cycle during RUN → ready low 3 cycles later, relock restarts hold; first ch0 pulse again at R'+5.
- CLKEN_RUNTIME_CFG_EN: write ch0 NUM=1 DEN=3 midway between pulses → next pulse at old spacing, then every 3 cycles; write cfg_ch=7 with NUM_CH=2 → no change.
- DEN=0 and NUM=0 channels → ce stays 0 through RUN and relock.
